// File: rtl/bsg_tag_pkg.sv
// bsg_tag_pkg: shared bsg_tag packet-format constants and header layout.
//   bsg_tag_header_s       : {nodeID, data_not_reset, len}; shifted out LSB first
//   bsg_tag_hdr_width      : header bit count for given nodeID / length widths
//   bsg_tag_max_payload_w  : largest payload encodable in a length field
package bsg_tag_pkg;
   localparam int bsg_tag_els_gp      = 32;
   localparam int bsg_tag_lg_els_gp   = $clog2(bsg_tag_els_gp);
   localparam int bsg_tag_lg_width_gp = 4;
   typedef struct packed {
      logic [bsg_tag_lg_els_gp-1:0]   nodeID;
      logic                           data_not_reset;
      logic [bsg_tag_lg_width_gp-1:0] len;
   } bsg_tag_header_s;
   function automatic int bsg_tag_hdr_width(input int lg_els, input int lg_width);
      return lg_width + 1 + lg_els;
   endfunction
   function automatic int bsg_tag_max_payload_w(input int lg_width);
      return (1 << lg_width) - 1;
   endfunction
endpackage

// File: rtl/bsg_counter_set_down.sv
// bsg_counter_set_down: loadable down-counter with synchronous clear.
//   clk_i, reset_i : clock, sync active-high reset (clears count)
//   set_i, val_i   : load val_i (wins over down_i)
//   down_i         : decrement by one
//   count_r_o      : registered count
module bsg_counter_set_down #(
   parameter int width_p = 6
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               set_i,
   input  logic [width_p-1:0] val_i,
   input  logic               down_i,
   output logic [width_p-1:0] count_r_o
);
   logic [width_p-1:0] count_q, count_d;
   always_comb count_d = set_i ? val_i : down_i ? count_q - 1'b1 : count_q;
   always_ff @(posedge clk_i)
      count_q <= reset_i ? '0 : count_d;
   assign count_r_o = count_q;
endmodule

// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag_serial_tx: shifts parallel bsg_tag commands out as bsg_tag_data/bsg_tag_en.
//   clk_i, reset_i      : tag clock, sync active-high reset
//   v_i / ready_o       : command handshake, ready only in IDLE
//   master_reset_i      : send the master-reset run (ones then zeros) instead of a packet
//   node_id_i, data_not_reset_i, len_i, payload_i : packet fields
//   tag_data_o, tag_en_o: registered serial pins
//   busy_o              : any state other than IDLE
module bsg_tag_serial_tx
   import bsg_tag_pkg::*;
#(
   parameter int els_p       = 32,
   parameter int lg_width_p  = 4,
   parameter int reset_run_p = 2 * (((1 << lg_width_p) - 1) + $clog2(els_p) + lg_width_p + 2)
) (
   input  logic                                        clk_i,
   input  logic                                        reset_i,
   input  logic                                        v_i,
   output logic                                        ready_o,
   input  logic                                        master_reset_i,
   input  logic [$clog2(els_p)-1:0]                    node_id_i,
   input  logic                                        data_not_reset_i,
   input  logic [lg_width_p-1:0]                       len_i,
   input  logic [bsg_tag_max_payload_w(lg_width_p)-1:0] payload_i,
   output logic                                        tag_data_o,
   output logic                                        tag_en_o,
   output logic                                        busy_o
);
   localparam int lg_els_lp            = $clog2(els_p);
   localparam int max_payload_width_lp = bsg_tag_max_payload_w(lg_width_p);
   localparam int hdr_w_lp             = bsg_tag_hdr_width(lg_els_lp, lg_width_p);
   localparam int sr_w_lp              = 1 + hdr_w_lp + max_payload_width_lp;
   localparam int max_cnt_lp           = reset_run_p > max_payload_width_lp ? reset_run_p : max_payload_width_lp;
   localparam int cw_lp                = $clog2(max_cnt_lp + 1);
   localparam logic [cw_lp-1:0] run_m1_lp = cw_lp'(reset_run_p - 1);
   localparam logic [cw_lp-1:0] hdr_m1_lp = cw_lp'(hdr_w_lp - 1);

   typedef enum logic [2:0] {IDLE, RST1, RST0, START, HDR, PAY} state_e;

   state_e                 state_q, state_d;
   logic [sr_w_lp-1:0]     sr_q, sr_d;
   logic [lg_width_p-1:0]  len_q, len_d;
   logic                   data_q, data_d, en_q, en_d;
   logic                   cnt_set, cnt_down, last;
   logic [cw_lp-1:0]       cnt, cnt_val;

   bsg_counter_set_down #(.width_p(cw_lp)) cnt_u (
      .clk_i(clk_i), .reset_i(reset_i), .set_i(cnt_set), .val_i(cnt_val),
      .down_i(cnt_down), .count_r_o(cnt)
   );

   // the counter holds cycles remaining in the current state minus one
   assign last = cnt == '0;

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      len_d    = len_q;
      cnt_set  = 1'b0;
      cnt_down = 1'b0;
      cnt_val  = '0;
      case (state_q)
         IDLE: if (v_i) begin
            if (master_reset_i) begin
               state_d = RST1;
               cnt_set = 1'b1;
               cnt_val = run_m1_lp;
            end else begin
               // start bit in sr[0]; header order matches bsg_tag_header_s
               state_d = START;
               sr_d    = {payload_i, node_id_i, data_not_reset_i, len_i, 1'b1};
               len_d   = len_i;
            end
         end
         RST1: if (last) begin
            state_d = RST0;
            cnt_set = 1'b1;
            cnt_val = run_m1_lp;
         end else cnt_down = 1'b1;
         RST0: if (last) state_d = IDLE; else cnt_down = 1'b1;
         START: begin
            state_d = HDR;
            sr_d    = sr_q >> 1;
            cnt_set = 1'b1;
            cnt_val = hdr_m1_lp;
         end
         HDR: begin
            sr_d = sr_q >> 1;
            if (last) begin
               state_d = len_q != '0 ? PAY : IDLE;
               cnt_set = len_q != '0;
               cnt_val = cw_lp'(len_q - 1'b1);
            end else cnt_down = 1'b1;
         end
         PAY: begin
            sr_d = sr_q >> 1;
            if (last) state_d = IDLE; else cnt_down = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      en_d   = state_d != IDLE;
      data_d = (state_d == RST1) | (sr_d[0] & (state_d inside {START, HDR, PAY}));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         sr_q    <= '0;
         len_q   <= '0;
         data_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         len_q   <= len_d;
         data_q  <= data_d;
         en_q    <= en_d;
      end
   end

   assign ready_o    = state_q == IDLE;
   assign busy_o     = state_q != IDLE;
   assign tag_data_o = data_q;
   assign tag_en_o   = en_q;
endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// tb_bsg_tag_serial_tx: directed self-checking bench for bsg_tag_serial_tx.
module tb_bsg_tag_serial_tx;
   logic        clk = 1'b0;
   logic        reset_i = 1'b1, v_i = 1'b0, master_reset_i = 1'b0, data_not_reset_i = 1'b0;
   logic [4:0]  node_id_i = '0;
   logic [3:0]  len_i = '0;
   logic [14:0] payload_i = '0;
   logic        ready_o, tag_data_o, tag_en_o, busy_o;
   int          checks = 0, failures = 0;
   logic [127:0] en_v, dat_v, rdy_v;
   logic [127:0] one = 128'd1;

   bsg_tag_serial_tx dut (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
      .master_reset_i(master_reset_i), .node_id_i(node_id_i),
      .data_not_reset_i(data_not_reset_i), .len_i(len_i), .payload_i(payload_i),
      .tag_data_o(tag_data_o), .tag_en_o(tag_en_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cmd(input logic mr, input logic [4:0] node, input logic dnr,
                      input logic [3:0] len, input logic [14:0] pay);
      @(negedge clk);
      v_i = 1'b1; master_reset_i = mr; node_id_i = node;
      data_not_reset_i = dnr; len_i = len; payload_i = pay;
   endtask

   // sample n cycles starting with the cycle after the accept edge
   task automatic capture(input int n);
      en_v = '0; dat_v = '0; rdy_v = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en_v[i] = tag_en_o; dat_v[i] = tag_data_o; rdy_v[i] = ready_o;
         if (i == 0) v_i = 1'b0;
      end
   endtask

   task automatic decode(input string tag, input logic [4:0] node, input logic dnr, input logic [3:0] len);
      chk({tag, "_len"}, 128'(dat_v[4:1]), 128'(len));
      chk({tag, "_dnr"}, 128'(dat_v[5]), 128'(dnr));
      chk({tag, "_node"}, 128'(dat_v[10:6]), 128'(node));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_en", 128'(tag_en_o), 0);
      chk("rst_data", 128'(tag_data_o), 0);
      chk("rst_ready", 128'(ready_o), 1);
      chk("rst_busy", 128'(busy_o), 0);
      reset_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle", 128'({tag_en_o, tag_data_o, ready_o}), 128'(3'b001));
      end

      cmd(1'b1, 5'd0, 1'b0, 4'd0, 15'd0);
      capture(105);
      chk("mr_en", en_v, (one << 104) - one);
      chk("mr_data", dat_v, (one << 52) - one);
      chk("mr_ready", rdy_v, one << 104);

      cmd(1'b0, 5'd19, 1'b1, 4'd5, 15'h7FF6);
      capture(17);
      chk("pkt_en", en_v, 128'h0FFFF);
      chk("pkt_data", dat_v, 128'h0B4EB);
      chk("pkt_ready", rdy_v, 128'h10000);

      cmd(1'b0, 5'd3, 1'b0, 4'd0, 15'h7FFF);
      capture(12);
      chk("len0_en", en_v, 128'h7FF);
      chk("len0_data", dat_v, 128'h0C1);
      chk("len0_ready", rdy_v, 128'h800);
      decode("len0", 5'd3, 1'b0, 4'd0);

      cmd(1'b0, 5'd7, 1'b1, 4'd2, 15'h7FFC);
      en_v = '0; dat_v = '0; rdy_v = '0;
      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         en_v[i] = tag_en_o; dat_v[i] = tag_data_o; rdy_v[i] = ready_o;
         if (i == 0) begin
            node_id_i = 5'd21; data_not_reset_i = 1'b0; len_i = 4'd3; payload_i = 15'h7FF9;
         end
         if (i == 14) v_i = 1'b0;
      end
      chk("b2b_en", en_v, 128'h0FFFDFFF);
      chk("b2b_data", dat_v, 128'h0351C1E5);
      chk("b2b_ready", rdy_v, 128'h10002000);

      cmd(1'b0, 5'd19, 1'b1, 4'd5, 15'h7FF6);
      capture(13);
      chk("abort_pre_data", dat_v, 128'h0B4EB & ((one << 13) - one));
      reset_i = 1'b1;
      @(negedge clk);
      chk("abort_en", 128'(tag_en_o), 0);
      chk("abort_data", 128'(tag_data_o), 0);
      chk("abort_ready", 128'(ready_o), 1);
      reset_i = 1'b0;
      cmd(1'b1, 5'd0, 1'b0, 4'd0, 15'd0);
      capture(105);
      chk("abort_mr_data", dat_v, (one << 52) - one);
      chk("abort_mr_ready", rdy_v, one << 104);
      cmd(1'b0, 5'd3, 1'b0, 4'd0, 15'h0);
      capture(12);
      chk("abort_pkt_data", dat_v, 128'h0C1);
      decode("abort_pkt", 5'd3, 1'b0, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
